// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data-memory request/response path.
package mem_if_pkg;

    // RV32I load/store funct3 encodings
    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [2:0]  func3;
        logic [31:0] wdata;
    } mem_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } mem_rsp_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// Load/Store-stage data-memory bus: one request channel, one response channel.
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [2:0]  req_func3;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_func3, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_func3, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_responder_align.sv
// Byte-lane steering: store enables/replication, load select/extension,
// and misaligned / illegal-funct3 detection. Purely combinational.
module mem_lane_align
    import mem_if_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  func3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] ldata,
    output logic        misalign,
    output logic        illegal
);
    logic [31:0] bshift;
    logic [7:0]  bsel;
    logic [15:0] hsel;

    assign bshift = rword >> {addr_lo, 3'b000};
    assign bsel   = bshift[7:0];
    assign hsel   = addr_lo[1] ? rword[31:16] : rword[15:0];

    // Decode access size from funct3 and steer lanes accordingly
    always_comb begin
        be        = 4'b0000;
        wdata_rep = wdata;
        ldata     = 32'h0;
        misalign  = 1'b0;
        illegal   = 1'b0;
        if (we) begin
            case (func3)
                F3_B: begin
                    be        = 4'b0001 << addr_lo;
                    wdata_rep = {4{wdata[7:0]}};
                end
                F3_H: begin
                    be        = 4'b0011 << {addr_lo[1], 1'b0};
                    wdata_rep = {2{wdata[15:0]}};
                    misalign  = addr_lo[0];
                end
                F3_W: begin
                    be       = 4'b1111;
                    misalign = |addr_lo;
                end
                default: illegal = 1'b1;
            endcase
        end else begin
            case (func3)
                F3_B:  ldata = {{24{bsel[7]}}, bsel};
                F3_BU: ldata = {24'h0, bsel};
                F3_H: begin
                    ldata    = {{16{hsel[15]}}, hsel};
                    misalign = addr_lo[0];
                end
                F3_HU: begin
                    ldata    = {16'h0, hsel};
                    misalign = addr_lo[0];
                end
                F3_W: begin
                    ldata    = rword;
                    misalign = |addr_lo;
                end
                default: illegal = 1'b1;
            endcase
        end
    end
endmodule

// File: rtl/data_mem_responder.sv
// Data-side memory responder: one transaction at a time, WAIT_STATES extra
// cycles, array read/write committed on the edge that enters RESP.
module data_mem_responder
    import mem_if_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_2000
) (
    input  logic                 clk,
    input  logic                 rstn,
    data_mem_responder_if.slave  bus
);
    localparam int          AW   = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) * 33'd4;

    state_t      state;
    logic [3:0]  cnt;
    mem_req_t    req_q;
    mem_req_t    cur;
    logic [31:0] mem [DEPTH_WORDS];

    logic        accept, commit, wr_en, oor, err;
    logic [31:0] offset;
    logic [AW-1:0] widx;
    logic [3:0]  be;
    logic [31:0] wdata_rep, ldata;
    logic        misalign, illegal;
    logic        rsp_valid_q, err_q;
    logic [31:0] rdata_q;

    assign accept = bus.req_valid && (state == IDLE);

    // With zero wait states the commit edge is the accept edge, so decode
    // straight from the bus; otherwise decode from the latched request.
    assign cur = (state == IDLE) ? '{we: bus.req_we, addr: bus.req_addr,
                                     func3: bus.req_func3, wdata: bus.req_wdata}
                                 : req_q;

    // Unsigned subtract folds addresses below BASE_ADDR into the high range
    assign offset = cur.addr - BASE_ADDR;
    assign widx   = offset[AW+1:2];
    assign oor    = {1'b0, offset} >= SPAN;

    mem_lane_align u_align (
        .we        (cur.we),
        .func3     (cur.func3),
        .addr_lo   (offset[1:0]),
        .wdata     (cur.wdata),
        .rword     (mem[widx]),
        .be        (be),
        .wdata_rep (wdata_rep),
        .ldata     (ldata),
        .misalign  (misalign),
        .illegal   (illegal)
    );

    assign err    = oor | misalign | illegal;
    assign commit = (WAIT_STATES == 0) ? accept : (state == WAIT && cnt == 4'd1);
    // rstn gate keeps a store from landing while reset is held
    assign wr_en  = commit && cur.we && !err && rstn;

    // Request/response FSM with registered response fields
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            req_q       <= '0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= 32'h0;
            err_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    req_q <= cur;
                    cnt   <= 4'(WAIT_STATES);
                    state <= (WAIT_STATES == 0) ? RESP : WAIT;
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= RESP;
                end
                RESP: if (bus.rsp_ready) begin
                    state       <= IDLE;
                    rsp_valid_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
            if (commit) begin
                rsp_valid_q <= 1'b1;
                rdata_q     <= (err || cur.we) ? 32'h0 : ldata;
                err_q       <= err;
            end
        end
    end

    // Storage array: not reset, so contents survive rstn
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[widx][8*i +: 8] <= wdata_rep[8*i +: 8];
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench: three responders (0, 1 and 3 wait states) checked against a
// byte-addressed reference memory with directed and random traffic.
module tb_data_mem_responder;
    localparam logic [31:0] BASE  = 32'h0000_2000;
    localparam int          BYTES = 4096;

    logic              clk = 1'b0;
    logic [2:0]        rstn;
    logic [2:0]        req_valid;
    logic              req_we;
    logic [31:0]       req_addr, req_wdata;
    logic [2:0]        req_func3;
    logic              rsp_ready;
    logic [2:0]        rq_rdy, rs_vld, rs_err;
    logic [2:0][31:0]  rs_rdata;

    int tests = 0;
    int fails = 0;
    byte unsigned mem_m [3][BYTES];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        data_mem_responder_if bus ();
        data_mem_responder #(
            .DEPTH_WORDS (1024),
            .WAIT_STATES ((g == 0) ? 0 : (g == 1) ? 1 : 3),
            .BASE_ADDR   (BASE)
        ) dut (
            .clk  (clk),
            .rstn (rstn[g]),
            .bus  (bus.slave)
        );
        assign bus.req_valid = req_valid[g];
        assign bus.req_we    = req_we;
        assign bus.req_addr  = req_addr;
        assign bus.req_func3 = req_func3;
        assign bus.req_wdata = req_wdata;
        assign bus.rsp_ready = rsp_ready;
        assign rq_rdy[g]     = bus.req_ready;
        assign rs_vld[g]     = bus.rsp_valid;
        assign rs_err[g]     = bus.rsp_err;
        assign rs_rdata[g]   = bus.rsp_rdata;
    end

    function automatic int ws(input int d);
        return (d == 0) ? 0 : (d == 1) ? 1 : 3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: RV32I semantics on a flat byte array
    task automatic model(input int d, input bit we, input logic [31:0] addr,
                         input logic [2:0] f3, input logic [31:0] wd,
                         output logic [31:0] rd, output bit err);
        logic [31:0] off;
        int size;
        bit sgn;
        off = addr - BASE;
        size = 0;
        sgn = 0;
        if (we) begin
            case (f3)
                3'd0: size = 1;
                3'd1: size = 2;
                3'd2: size = 4;
                default: size = 0;
            endcase
        end else begin
            case (f3)
                3'd0: begin size = 1; sgn = 1; end
                3'd1: begin size = 2; sgn = 1; end
                3'd2: size = 4;
                3'd4: size = 1;
                3'd5: size = 2;
                default: size = 0;
            endcase
        end
        err = (size == 0) || (off >= BYTES);
        if (!err) err = (addr % size) != 0;
        rd = 32'h0;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < size; i++) mem_m[d][off + i] = wd[8*i +: 8];
            end else begin
                for (int i = 0; i < size; i++) rd = rd | (32'(mem_m[d][off + i]) << (8*i));
                if (sgn && size < 4 && rd[8*size-1]) rd = rd | (32'hFFFF_FFFF << (8*size));
            end
        end
    endtask

    // One full transaction; called and returning at a negedge
    task automatic txn(input int d, input bit we, input logic [31:0] addr,
                       input logic [2:0] f3, input logic [31:0] wd,
                       input int stall, input string tag);
        logic [31:0] erd, held;
        bit eerr;
        int lat;
        model(d, we, addr, f3, wd, erd, eerr);
        chk({tag, " req_ready idle"}, {31'h0, rq_rdy[d]}, 32'h1);
        req_we = we; req_addr = addr; req_func3 = f3; req_wdata = wd;
        req_valid[d] = 1'b1;
        rsp_ready = (stall == 0);
        @(posedge clk); lat = 1;
        @(negedge clk);
        req_valid[d] = 1'b0;
        req_addr = $urandom; req_wdata = $urandom;
        while (!rs_vld[d] && lat < 40) begin
            @(posedge clk); lat++;
            @(negedge clk);
        end
        chk({tag, " latency"}, 32'(lat), 32'(1 + ws(d)));
        chk({tag, " rdata"}, rs_rdata[d], erd);
        chk({tag, " err"}, {31'h0, rs_err[d]}, {31'h0, eerr});
        held = rs_rdata[d];
        for (int k = 0; k < stall; k++) begin
            req_valid[d] = k[0];
            req_we = 1'b1; req_func3 = 3'd2; req_addr = BASE + 32'h10;
            @(posedge clk); @(negedge clk);
            chk({tag, " stall valid"}, {31'h0, rs_vld[d]}, 32'h1);
            chk({tag, " stall rdata"}, rs_rdata[d], held);
            chk({tag, " stall ready"}, {31'h0, rq_rdy[d]}, 32'h0);
        end
        req_valid[d] = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        chk({tag, " post valid"}, {31'h0, rs_vld[d]}, 32'h0);
        chk({tag, " post ready"}, {31'h0, rq_rdy[d]}, 32'h1);
    endtask

    initial begin
        logic [31:0] a, w;
        logic [2:0] f;
        bit we;
        rstn = 3'b000; req_valid = 3'b000; req_we = 0; req_addr = 0;
        req_func3 = 0; req_wdata = 0; rsp_ready = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("reset req_ready", {31'h0, rq_rdy[d]}, 32'h1);
            chk("reset rsp_valid", {31'h0, rs_vld[d]}, 32'h0);
            chk("reset rsp_rdata", rs_rdata[d], 32'h0);
            chk("reset rsp_err", {31'h0, rs_err[d]}, 32'h0);
        end
        rstn = 3'b111;
        @(negedge clk);

        // Known contents for the first 64 words of each array
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < 64; i++)
                txn(d, 1, BASE + 32'(4*i), 3'd2, $urandom, 0, "init");

        // Directed sequence on the one-wait-state responder
        txn(1, 1, 32'h2004, 3'd2, 32'hDEADBEEF, 0, "SW 2004");
        txn(1, 0, 32'h2004, 3'd2, 0, 0, "LW 2004");
        txn(1, 0, 32'h2007, 3'd0, 0, 0, "LB 2007");
        txn(1, 0, 32'h2007, 3'd4, 0, 0, "LBU 2007");
        txn(1, 0, 32'h2006, 3'd1, 0, 0, "LH 2006");
        txn(1, 0, 32'h2004, 3'd5, 0, 0, "LHU 2004");
        txn(1, 1, 32'h2005, 3'd0, 32'h11, 0, "SB 2005");
        txn(1, 0, 32'h2004, 3'd2, 0, 0, "LW after SB");
        chk("model SB word", {8'(mem_m[1][7]), 8'(mem_m[1][6]), 8'(mem_m[1][5]), 8'(mem_m[1][4])}, 32'hDEAD11EF);
        txn(1, 1, 32'h2006, 3'd1, 32'h1234, 0, "SH 2006");
        txn(1, 0, 32'h2004, 3'd2, 0, 0, "LW after SH");
        chk("model SH word", {8'(mem_m[1][7]), 8'(mem_m[1][6]), 8'(mem_m[1][5]), 8'(mem_m[1][4])}, 32'h123411EF);
        txn(1, 0, 32'h2002, 3'd2, 0, 0, "LW misaligned");
        txn(1, 1, 32'h1FFC, 3'd2, 32'hCAFEF00D, 0, "SW below base");
        txn(1, 0, 32'h2000, 3'd2, 0, 0, "LW 2000 unchanged");
        txn(1, 0, BASE + 32'(BYTES), 3'd2, 0, 0, "LW past end");
        txn(1, 0, 32'h2004, 3'd3, 0, 0, "load f3=3");
        txn(1, 0, 32'h2004, 3'd2, 0, 5, "backpressure");
        txn(0, 0, 32'h2004, 3'd2, 0, 3, "backpressure ws0");

        // Reset in the middle of a three-wait-state store
        req_we = 1; req_addr = 32'h2008; req_func3 = 3'd2; req_wdata = 32'hA5A5A5A5;
        req_valid[2] = 1'b1;
        @(posedge clk); @(negedge clk);
        req_valid[2] = 1'b0;
        @(posedge clk); @(negedge clk);
        rstn[2] = 1'b0;
        #1;
        chk("midreset rsp_valid", {31'h0, rs_vld[2]}, 32'h0);
        chk("midreset req_ready", {31'h0, rq_rdy[2]}, 32'h1);
        chk("midreset rsp_rdata", rs_rdata[2], 32'h0);
        @(posedge clk); @(negedge clk);
        rstn[2] = 1'b1;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        txn(2, 0, 32'h2008, 3'd2, 0, 0, "LW after reset");

        // Random traffic on every responder
        for (int d = 0; d < 3; d++) begin
            for (int n = 0; n < 150; n++) begin
                we = $urandom_range(0, 1);
                f  = 3'($urandom_range(0, 7));
                w  = $urandom;
                case ($urandom_range(0, 9))
                    0: a = BASE + 32'(BYTES) + 32'($urandom_range(0, 300));
                    1: a = BASE - 32'($urandom_range(1, 300));
                    default: a = BASE + 32'($urandom_range(0, 255));
                endcase
                txn(d, we, a, f, w, $urandom_range(0, 2), "random");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
